// File: rtl/mem_write_checker.sv
// Store monitor: checks MemWrite/DataAdr/WDFinal against an ordered table of expected stores.
// Optional watchdog enabled by defining MWC_TIMEOUT_EN.
module mem_write_checker #(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [ADDR_W-1:0]    IGN_ADDR   = ADDR_W'(96),
  parameter int unsigned          TIMEOUT_W  = 16,
  parameter int unsigned          TIMEOUT_CY = 1000,
  localparam int unsigned         IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_num,
  input  logic              arm,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WDFinal,
  output logic              armed,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [IDX_W:0]    match_cnt,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_data
);

  if (64'(TIMEOUT_CY) >= (64'd1 << TIMEOUT_W)) begin : g_tmo_range
    $error("TIMEOUT_CY must be below 2**TIMEOUT_W");
  end

  typedef enum logic [2:0] {StIdle, StArmed, StPass, StFail, StTimeout} state_e;

  state_e            r_state;
  logic [IDX_W:0]    r_num;
  logic [IDX_W:0]    r_cnt;
  logic [ADDR_W-1:0] r_fail_adr;
  logic [DATA_W-1:0] r_fail_data;
  logic [ADDR_W-1:0] r_exp_addr [DEPTH];
  logic [DATA_W-1:0] r_exp_data [DEPTH];

  logic [IDX_W-1:0]  w_ptr;
  logic [IDX_W:0]    w_num;
  logic              w_hit;
  logic              w_ign;
  logic              w_last;
  logic              w_cfg_ok;
  logic              w_tmo;

  // match count doubles as the table pointer; it never reaches DEPTH while armed
  assign w_ptr    = r_cnt[IDX_W-1:0];
  assign w_num    = (cfg_num > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : cfg_num;
  assign w_hit    = (DataAdr == r_exp_addr[w_ptr]) && (WDFinal == r_exp_data[w_ptr]);
  assign w_ign    = (DataAdr == IGN_ADDR);
  assign w_last   = ((r_cnt + 1'b1) == r_num);
  assign w_cfg_ok = cfg_we && (r_state != StArmed) && ({1'b0, cfg_idx} < (IDX_W+1)'(DEPTH));

`ifdef MWC_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TmoLast = TIMEOUT_W'(TIMEOUT_CY - 1);
  logic [TIMEOUT_W-1:0] r_timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (arm) begin
      r_timer <= '0;
    end else if (r_state == StArmed) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_tmo = (r_state == StArmed) && (r_timer == TmoLast);
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_exp_addr[i] <= '0;
        r_exp_data[i] <= '0;
      end
    end else if (w_cfg_ok) begin
      r_exp_addr[cfg_idx] <= cfg_addr;
      r_exp_data[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_num       <= '0;
      r_cnt       <= '0;
      r_fail_adr  <= '0;
      r_fail_data <= '0;
    end else if (arm) begin
      r_cnt   <= '0;
      r_num   <= w_num;
      r_state <= (w_num == '0) ? StPass : StArmed;
    end else if (r_state == StArmed) begin
      if (MemWrite && w_hit) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_state <= StPass;
        end else if (w_tmo) begin
          r_state <= StTimeout;
        end
      end else if (MemWrite && !w_ign) begin
        r_state     <= StFail;
        r_fail_adr  <= DataAdr;
        r_fail_data <= WDFinal;
      end else if (w_tmo) begin
        r_state <= StTimeout;
      end
    end
  end

  assign armed     = (r_state == StArmed);
  assign pass      = (r_state == StPass);
  assign fail      = (r_state == StFail);
  assign timeout   = (r_state == StTimeout);
  assign done      = pass | fail | timeout;
  assign match_cnt = r_cnt;
  assign fail_adr  = r_fail_adr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus random stores against a queue-based model.
module tb_mem_write_checker;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned TCY   = 10;
  localparam logic [31:0] IGN   = 32'd96;
  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_PASS = 2, ST_FAIL = 3, ST_TMO = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [31:0]       cfg_addr, cfg_data;
  logic [IDX_W:0]    cfg_num;
  logic              arm, MemWrite;
  logic [31:0]       DataAdr, WDFinal;
  logic              armed, done, pass, fail, timeout;
  logic [IDX_W:0]    match_cnt;
  logic [31:0]       fail_adr, fail_data;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int          m_st, m_cnt, m_timer;
  logic [31:0] m_fa, m_fd;
  logic [31:0] m_tab_a [DEPTH];
  logic [31:0] m_tab_d [DEPTH];
  logic [31:0] q_a [$];
  logic [31:0] q_d [$];

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .IGN_ADDR(IGN), .TIMEOUT_W(16), .TIMEOUT_CY(TCY)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_num(cfg_num), .arm(arm), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WDFinal(WDFinal), .armed(armed), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .match_cnt(match_cnt), .fail_adr(fail_adr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_st = ST_IDLE; m_cnt = 0; m_timer = 0; m_fa = '0; m_fd = '0;
    q_a.delete(); q_d.delete();
    for (int i = 0; i < int'(DEPTH); i++) begin m_tab_a[i] = '0; m_tab_d[i] = '0; end
  endfunction

  function automatic void model_step(input logic we, input int idx, input logic [31:0] ca,
                                     input logic [31:0] cd, input int num, input logic ar,
                                     input logic mw, input logic [31:0] a, input logic [31:0] d);
    int ost;
    int n;
    ost = m_st;
    if (ar) begin
      n = (num > int'(DEPTH)) ? int'(DEPTH) : num;
      q_a.delete(); q_d.delete();
      for (int i = 0; i < n; i++) begin q_a.push_back(m_tab_a[i]); q_d.push_back(m_tab_d[i]); end
      m_cnt = 0; m_timer = 0;
      m_st = (n == 0) ? ST_PASS : ST_ARMED;
    end else if (m_st == ST_ARMED) begin
      if (mw && a == q_a[0] && d == q_d[0]) begin
        void'(q_a.pop_front()); void'(q_d.pop_front());
        m_cnt++;
        if (q_a.size() == 0) m_st = ST_PASS;
      end else if (mw && a != IGN) begin
        m_st = ST_FAIL; m_fa = a; m_fd = d;
      end
`ifdef MWC_TIMEOUT_EN
      if (m_st == ST_ARMED) begin
        if (m_timer == int'(TCY) - 1) m_st = ST_TMO;
        m_timer++;
      end
`endif
    end
    if (we && ost != ST_ARMED && idx < int'(DEPTH)) begin
      m_tab_a[idx] = ca; m_tab_d[idx] = cd;
    end
  endfunction

  task automatic cycle(input logic we, input int idx, input logic [31:0] ca, input logic [31:0] cd,
                       input int num, input logic ar, input logic mw, input logic [31:0] a,
                       input logic [31:0] d);
    cfg_we = we; cfg_idx = idx[IDX_W-1:0]; cfg_addr = ca; cfg_data = cd;
    cfg_num = num[IDX_W:0]; arm = ar; MemWrite = mw; DataAdr = a; WDFinal = d;
    model_step(we, idx, ca, cd, num, ar, mw, a, d);
    @(posedge clk); #1;
    cfg_we = 1'b0; arm = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, idx, a, d, 0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_arm(input int num);
    cycle(1'b0, 0, '0, '0, num, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 0, '0, '0, 0, 1'b0, 1'b1, a, d);
  endtask

  task automatic idle();
    cycle(1'b0, 0, '0, '0, 0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_we = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0; cfg_num = 0;
    arm = 0; MemWrite = 0; DataAdr = 0; WDFinal = 0;
    model_reset();
    #12;
    n_chk++;
    if ({armed, done, pass, fail, timeout, match_cnt, fail_adr, fail_data} !== '0)
      $display("FAIL reset_outputs: got %b%b%b%b%b cnt=%0d fa=%0d fd=%0d want all 0",
               armed, done, pass, fail, timeout, match_cnt, fail_adr, fail_data);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    // cleared table means entry 0 is (0,0)
    do_arm(1);
    store(32'd0, 32'd0);
    n_chk++;
    if ({pass, match_cnt} !== {1'b1, 3'd1})
      $display("FAIL reset_table_clear: got pass=%b cnt=%0d want pass=1 cnt=1", pass, match_cnt);
    else n_pass++;
  endtask

  task automatic test_t1_ignore();
    cfg(0, 32'd100, 32'd25);
    do_arm(1);
    n_chk++;
    if ({armed, done} !== 2'b10) $display("FAIL t1_armed: got %b%b want 10", armed, done);
    else n_pass++;
    store(32'd96, 32'd7);
    store(32'd96, 32'd9);
    n_chk++;
    if ({armed, match_cnt} !== {1'b1, 3'd0})
      $display("FAIL t1_ign_store: got armed=%b cnt=%0d want armed=1 cnt=0", armed, match_cnt);
    else n_pass++;
    store(32'd100, 32'd25);
    n_chk++;
    if ({armed, done, pass, fail, timeout, match_cnt} !== {5'b01100, 3'd1})
      $display("FAIL t1_pass: got %b%b%b%b%b cnt=%0d want 01100 cnt=1",
               armed, done, pass, fail, timeout, match_cnt);
    else n_pass++;
  endtask

  task automatic test_t2_wrong_data();
    do_arm(1);
    store(32'd100, 32'd24);
    n_chk++;
    if ({fail, pass, match_cnt, fail_adr, fail_data} !== {2'b10, 3'd0, 32'd100, 32'd24})
      $display("FAIL t2_wrong_data: got fail=%b pass=%b cnt=%0d fa=%0d fd=%0d want 1 0 0 100 24",
               fail, pass, match_cnt, fail_adr, fail_data);
    else n_pass++;
  endtask

  task automatic test_t3_ign_entry();
    cfg(0, 32'd96, 32'd5);
    cfg(1, 32'd100, 32'd25);
    do_arm(2);
    store(32'd96, 32'd5);
    n_chk++;
    if ({armed, match_cnt} !== {1'b1, 3'd1})
      $display("FAIL t3_ign_counted: got armed=%b cnt=%0d want 1 1", armed, match_cnt);
    else n_pass++;
    store(32'd100, 32'd25);
    n_chk++;
    if ({pass, match_cnt} !== {1'b1, 3'd2})
      $display("FAIL t3_pass: got pass=%b cnt=%0d want 1 2", pass, match_cnt);
    else n_pass++;
  endtask

  task automatic test_t4_terminal_hold();
    cfg(0, 32'd100, 32'd25);
    do_arm(1);
    store(32'd104, 32'd25);
    n_chk++;
    if ({fail, fail_adr, fail_data} !== {1'b1, 32'd104, 32'd25})
      $display("FAIL t4_fail: got fail=%b fa=%0d fd=%0d want 1 104 25", fail, fail_adr, fail_data);
    else n_pass++;
    store(32'd100, 32'd25);
    store(32'd108, 32'd1);
    store(32'd96, 32'd3);
    n_chk++;
    if ({armed, done, pass, fail, timeout, match_cnt, fail_adr, fail_data}
        !== {5'b01010, 3'd0, 32'd104, 32'd25})
      $display("FAIL t4_hold: got %b%b%b%b%b cnt=%0d fa=%0d fd=%0d want 01010 0 104 25",
               armed, done, pass, fail, timeout, match_cnt, fail_adr, fail_data);
    else n_pass++;
  endtask

  task automatic test_t5_timeout();
    do_arm(1);
    for (int i = 0; i < int'(TCY) - 1; i++) idle();
    n_chk++;
    if ({armed, timeout} !== 2'b10)
      $display("FAIL t5_before: got armed=%b timeout=%b want 1 0", armed, timeout);
    else n_pass++;
    idle();
`ifdef MWC_TIMEOUT_EN
    n_chk++;
    if ({armed, done, timeout} !== 3'b011)
      $display("FAIL t5_timeout: got armed=%b done=%b timeout=%b want 0 1 1", armed, done, timeout);
    else n_pass++;
`else
    n_chk++;
    if ({armed, done, timeout} !== 3'b100)
      $display("FAIL t5_no_timer: got armed=%b done=%b timeout=%b want 1 0 0", armed, done, timeout);
    else n_pass++;
`endif
  endtask

  task automatic test_t6_reset_mid();
    cfg(0, 32'd100, 32'd25);
    cfg(1, 32'd104, 32'd26);
    do_arm(2);
    store(32'd100, 32'd25);
    n_chk++;
    if ({armed, match_cnt} !== {1'b1, 3'd1})
      $display("FAIL t6_pre: got armed=%b cnt=%0d want 1 1", armed, match_cnt);
    else n_pass++;
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if ({armed, done, pass, fail, timeout, match_cnt, fail_adr, fail_data} !== '0)
      $display("FAIL t6_async_reset: got %b%b%b%b%b cnt=%0d want all 0",
               armed, done, pass, fail, timeout, match_cnt);
    else n_pass++;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    cfg(0, 32'd100, 32'd25);
    do_arm(1);
    store(32'd96, 32'd7);
    store(32'd96, 32'd9);
    store(32'd100, 32'd25);
    n_chk++;
    if ({pass, fail, match_cnt} !== {2'b10, 3'd1})
      $display("FAIL t6_rearm_pass: got pass=%b fail=%b cnt=%0d want 1 0 1", pass, fail, match_cnt);
    else n_pass++;
  endtask

  task automatic test_cfg_edges();
    do_arm(0);
    n_chk++;
    if ({pass, match_cnt} !== {1'b1, 3'd0})
      $display("FAIL num0_pass: got pass=%b cnt=%0d want 1 0", pass, match_cnt);
    else n_pass++;
    for (int i = 0; i < 4; i++) cfg(i, 32'd200 + 32'(i), 32'd10 + 32'(i));
    do_arm(7);
    for (int i = 0; i < 4; i++) store(32'd200 + 32'(i), 32'd10 + 32'(i));
    n_chk++;
    if ({pass, match_cnt} !== {1'b1, 3'd4})
      $display("FAIL num_clamp: got pass=%b cnt=%0d want 1 4", pass, match_cnt);
    else n_pass++;
    do_arm(1);
    cfg(0, 32'd300, 32'd1);
    store(32'd200, 32'd10);
    n_chk++;
    if (pass !== 1'b1) $display("FAIL cfg_drop_armed: got pass=%b want 1", pass);
    else n_pass++;
    cfg(0, 32'd300, 32'd1);
    do_arm(1);
    store(32'd300, 32'd1);
    n_chk++;
    if (pass !== 1'b1) $display("FAIL cfg_in_terminal: got pass=%b want 1", pass);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] pool [4];
    int r;
    pool[0] = 32'd96; pool[1] = 32'd100; pool[2] = 32'd104; pool[3] = 32'd108;
    for (int round = 0; round < 12; round++) begin
      for (int i = 0; i < 4; i++) cfg(i, pool[$urandom_range(0, 3)], 32'($urandom_range(0, 3)));
      do_arm($urandom_range(0, 5));
      for (int c = 0; c < 14; c++) begin
        r = $urandom_range(0, 11);
        if (r < 5 && q_a.size() > 0) store(q_a[0], q_d[0]);
        else if (r < 7) store(IGN, 32'($urandom_range(0, 3)));
        else if (r < 9) store(pool[$urandom_range(0, 3)], 32'($urandom_range(0, 3)));
        else if (r == 9) cfg($urandom_range(0, 3), pool[$urandom_range(0, 3)], 32'd2);
        else if (r == 10) do_arm($urandom_range(0, 5));
        else idle();
        n_chk++;
        if ({armed, done, pass, fail, timeout, match_cnt, fail_adr, fail_data} !==
            {m_st == ST_ARMED, m_st >= ST_PASS, m_st == ST_PASS, m_st == ST_FAIL, m_st == ST_TMO,
             3'(m_cnt), m_fa, m_fd})
          $display("FAIL rand_r%0d_c%0d: got st=%b%b%b%b%b cnt=%0d fa=%0d fd=%0d want st=%0d cnt=%0d fa=%0d fd=%0d",
                   round, c, armed, done, pass, fail, timeout, match_cnt, fail_adr, fail_data,
                   m_st, m_cnt, m_fa, m_fd);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_t1_ignore();
    test_t2_wrong_data();
    test_t3_ign_entry();
    test_t4_terminal_hold();
    test_t5_timeout();
    test_t6_reset_mid();
    test_cfg_edges();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
